// File: rtl/control_fsm_if.sv
// Datapath control bundle: instruction fields and PSR flags in, mux selects and strobes out.
// Latency: none; pure wiring between the controller and the datapath.
// Backpressure: none; the controller steps on every clock and the datapath always follows.
// Ports: master = control_fsm (drives selects/enables, reads instruction/PSR),
//        slave  = datapath (the reverse directions).
interface control_fsm_if #(
  parameter int REG_ADD = 4,
  parameter int PSRL    = 5
);
  logic [REG_ADD-1:0] OP_CODE;
  logic [REG_ADD-1:0] OP_EXT;
  logic [REG_ADD-1:0] Rdest_addr;
  logic [PSRL-1:0]    PSR_OUT;    // {N,Z,F,L,C}

  logic       PC_S;
  logic       MEM_S;
  logic [1:0] WD_S;
  logic [1:0] ALUA_S;
  logic [1:0] ALUB_S;
  logic       INSTR_EN;
  logic       ALU_OUT_EN;
  logic       MEM_REG_EN;
  logic       PC_EN;
  logic       PSR_EN;
  logic       SE_SIGN;
  logic       REG_WR;
  logic       MEM_WE;
  logic [3:0] state_out;

  modport master (
    input  OP_CODE, OP_EXT, Rdest_addr, PSR_OUT,
    output PC_S, MEM_S, WD_S, ALUA_S, ALUB_S,
           INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN,
           SE_SIGN, REG_WR, MEM_WE, state_out
  );

  modport slave (
    output OP_CODE, OP_EXT, Rdest_addr, PSR_OUT,
    input  PC_S, MEM_S, WD_S, ALUA_S, ALUB_S,
           INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN,
           SE_SIGN, REG_WR, MEM_WE, state_out
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle controller for the 16-bit core: sequences fetch/decode/execute/writeback.
// Latency: 4 cycles (CMP/MOV/STOR/branch/NOP), 5 (ALU reg/imm), 6 (LOAD); outputs combinational from state.
// Backpressure: none; one instruction in flight, state advances every clock.
// Ports: clk, reset (synchronous, active high), bus (control_fsm_if.master).
// Option: CTRL_BRANCH_EN enables Bcond/Jcond; without it both decode as NOPs and
//         the condition-evaluation logic is absent.
module control_fsm (
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH0 = 4'd0,
    FETCH1 = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    ALUWB  = 4'd4,
    MEMLAT = 4'd5,
    LDWB   = 4'd6
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JCND = 4'b1100;

  state_e state_q, state_d;

`ifdef CTRL_BRANCH_EN
  logic flag_n, flag_z, flag_f, flag_l, flag_c;
  logic cond_true;

  assign {flag_n, flag_z, flag_f, flag_l, flag_c} = bus.PSR_OUT;

  always_comb begin
    cond_true = 1'b0;
    case (bus.Rdest_addr)
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_l;
      4'b0101: cond_true = !flag_l;
      4'b0110: cond_true = flag_n;
      4'b0111: cond_true = !flag_n;
      4'b1000: cond_true = flag_f;
      4'b1001: cond_true = !flag_f;
      4'b1010: cond_true = !flag_l && !flag_z;
      4'b1011: cond_true = flag_l || flag_z;
      4'b1100: cond_true = !flag_n && !flag_z;
      4'b1101: cond_true = flag_n || flag_z;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end
`else
  // Condition inputs are only meaningful with branches compiled in.
  logic unused_cond;
  assign unused_cond = ^{bus.Rdest_addr, bus.PSR_OUT};
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = FETCH0;
    bus.PC_S       = 1'b0;
    bus.MEM_S      = 1'b0;
    bus.WD_S       = 2'd0;
    bus.ALUA_S     = 2'd0;
    bus.ALUB_S     = 2'd0;
    bus.INSTR_EN   = 1'b0;
    bus.ALU_OUT_EN = 1'b0;
    bus.MEM_REG_EN = 1'b0;
    bus.PC_EN      = 1'b0;
    bus.PSR_EN     = 1'b0;
    bus.SE_SIGN    = 1'b0;
    bus.REG_WR     = 1'b0;
    bus.MEM_WE     = 1'b0;
    bus.state_out  = state_q;

    case (state_q)
      FETCH0: begin
        bus.MEM_S = 1'b1;
        state_d   = FETCH1;
      end
      FETCH1: begin
        // PC <- PC + 1 while the fetched word is latched.
        bus.MEM_S    = 1'b1;
        bus.INSTR_EN = 1'b1;
        bus.PC_EN    = 1'b1;
        bus.ALUA_S   = 2'd1;
        bus.ALUB_S   = 2'd2;
        bus.PC_S     = 1'b1;
        state_d      = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (bus.OP_CODE)
          OP_RTYPE: begin
            if (bus.OP_EXT == EXT_MOV) begin
              bus.WD_S   = 2'd1;
              bus.REG_WR = 1'b1;
            end else if (bus.OP_EXT == EXT_CMP) begin
              bus.PSR_EN = 1'b1;
            end else begin
              bus.ALU_OUT_EN = 1'b1;
              bus.PSR_EN     = (bus.OP_EXT == EXT_ADD) || (bus.OP_EXT == EXT_SUB);
              state_d        = ALUWB;
            end
          end
          OP_ANDI, OP_ORI, OP_XORI: begin
            bus.ALUA_S     = 2'd2;
            bus.ALU_OUT_EN = 1'b1;
            state_d        = ALUWB;
          end
          OP_ADDI, OP_SUBI: begin
            bus.ALUA_S     = 2'd2;
            bus.SE_SIGN    = 1'b1;
            bus.ALU_OUT_EN = 1'b1;
            bus.PSR_EN     = 1'b1;
            state_d        = ALUWB;
          end
          OP_CMPI: begin
            bus.ALUA_S  = 2'd2;
            bus.SE_SIGN = 1'b1;
            bus.PSR_EN  = 1'b1;
          end
          OP_MOVI: begin
            bus.REG_WR = 1'b1;
          end
          OP_MEM: begin
            if (bus.OP_EXT == EXT_LOAD) begin
              state_d = MEMLAT;
            end else if (bus.OP_EXT == EXT_STOR) begin
              bus.MEM_WE = 1'b1;
            end
`ifdef CTRL_BRANCH_EN
            else if (bus.OP_EXT == EXT_JCND && cond_true) begin
              bus.PC_EN = 1'b1;
            end
`endif
          end
`ifdef CTRL_BRANCH_EN
          OP_BCOND: begin
            // PC <- PC + 1 + sext(disp8); PC already holds PC+1 from FETCH1.
            if (cond_true) begin
              bus.PC_EN   = 1'b1;
              bus.ALUA_S  = 2'd1;
              bus.ALUB_S  = 2'd1;
              bus.PC_S    = 1'b1;
              bus.SE_SIGN = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      ALUWB: begin
        bus.WD_S   = 2'd3;
        bus.REG_WR = 1'b1;
      end
      MEMLAT: begin
        bus.MEM_REG_EN = 1'b1;
        state_d        = LDWB;
      end
      LDWB: begin
        bus.WD_S   = 2'd2;
        bus.REG_WR = 1'b1;
      end
      default: state_d = FETCH0;
    endcase

    // Reset wins over the current state so an abandoned instruction can never
    // strobe a register or memory write.
    if (reset) begin
      bus.PC_S       = 1'b0;
      bus.MEM_S      = 1'b1;
      bus.WD_S       = 2'd0;
      bus.ALUA_S     = 2'd0;
      bus.ALUB_S     = 2'd0;
      bus.INSTR_EN   = 1'b0;
      bus.ALU_OUT_EN = 1'b0;
      bus.MEM_REG_EN = 1'b0;
      bus.PC_EN      = 1'b0;
      bus.PSR_EN     = 1'b0;
      bus.SE_SIGN    = 1'b0;
      bus.REG_WR     = 1'b0;
      bus.MEM_WE     = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle expected output vectors are queued by the
// stimulus process and popped/compared by an independent monitor on the falling edge.
module tb_control_fsm;

  logic clk = 1'b0;
  logic reset;

  control_fsm_if bus ();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Vector layout: {state[3:0], PC_S, MEM_S, WD_S[1:0], ALUA_S[1:0], ALUB_S[1:0], enables[7:0]}
  // enables = {INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE}
  localparam logic [7:0] E_INSTR = 8'h80;
  localparam logic [7:0] E_ALUO  = 8'h40;
  localparam logic [7:0] E_MREG  = 8'h20;
  localparam logic [7:0] E_PC    = 8'h10;
  localparam logic [7:0] E_PSR   = 8'h08;
  localparam logic [7:0] E_SE    = 8'h04;
  localparam logic [7:0] E_RW    = 8'h02;
  localparam logic [7:0] E_WE    = 8'h01;

  localparam logic [19:0] M_ALL   = 20'hFFFFF;
  localparam logic [19:0] M_STEN  = 20'hF00FF;  // state + enables only

  typedef struct {
    string       name;
    logic [19:0] v;
    logic [19:0] m;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [19:0] ev(input logic [3:0] st, input logic pc_s, input logic mem_s,
                                     input logic [1:0] wd, input logic [1:0] alua,
                                     input logic [1:0] alub, input logic [7:0] en);
    return {st, pc_s, mem_s, wd, alua, alub, en};
  endfunction

  logic [19:0] act;
  assign act = {bus.state_out, bus.PC_S, bus.MEM_S, bus.WD_S, bus.ALUA_S, bus.ALUB_S,
                bus.INSTR_EN, bus.ALU_OUT_EN, bus.MEM_REG_EN, bus.PC_EN, bus.PSR_EN,
                bus.SE_SIGN, bus.REG_WR, bus.MEM_WE};

  // Monitor: the controller presents a new output vector every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ((act & e.m) !== (e.v & e.m)) begin
        failures++;
        $display("FAIL %s: got %05h required %05h (mask %05h)", e.name, act, e.v, e.m);
      end
    end
  end

  task automatic cyc(input string name, input logic [19:0] v, input logic [19:0] m = M_ALL);
    exp_t e;
    e.name = name;
    e.v    = v;
    e.m    = m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] ext,
                           input logic [3:0] rd, input logic [4:0] psr);
    bus.OP_CODE    = op;
    bus.OP_EXT     = ext;
    bus.Rdest_addr = rd;
    bus.PSR_OUT    = psr;
  endtask

  // Fetch and decode are identical for every instruction.
  task automatic fetch(input string tag);
    cyc({tag, "_f0"},  ev(4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00));
    cyc({tag, "_f1"},  ev(4'd1, 1'b1, 1'b1, 2'd0, 2'd1, 2'd2, E_INSTR | E_PC));
    cyc({tag, "_dec"}, ev(4'd2, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00));
  endtask

  localparam logic [19:0] V_NOP_EX = {4'd3, 16'h0000};
  localparam logic [19:0] V_ALUWB  = {4'd4, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 8'h02};

  initial begin
    reset = 1'b1;
    set_instr(4'b0000, 4'b0101, 4'd0, 5'd0);
    @(posedge clk);
    #1;
    cyc("rst_state", ev(4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00));
    reset = 1'b0;

    // ADD: 0,1,2,3,4 then back to 0
    set_instr(4'b0000, 4'b0101, 4'd0, 5'd0);
    fetch("add");
    cyc("add_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_ALUO | E_PSR));
    cyc("add_wb", V_ALUWB);

    // ANDI: logical immediate, zero-extended, flags untouched
    set_instr(4'b0001, 4'b0000, 4'd0, 5'd0);
    fetch("andi");
    cyc("andi_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, E_ALUO));
    cyc("andi_wb", V_ALUWB);

    // LOAD: 6 cycles
    set_instr(4'b0100, 4'b0000, 4'd3, 5'd0);
    fetch("load");
    cyc("load_exec",   ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00));
    cyc("load_memlat", ev(4'd5, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_MREG));
    cyc("load_ldwb",   ev(4'd6, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, E_RW));

    // LOAD abandoned by a 2-cycle reset in LDWB
    set_instr(4'b0100, 4'b0000, 4'd3, 5'd0);
    fetch("ldrst");
    cyc("ldrst_exec",   ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00));
    cyc("ldrst_memlat", ev(4'd5, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_MREG));
    reset = 1'b1;
    cyc("ldrst_rst1", ev(4'd6, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00), M_STEN);
    cyc("ldrst_rst2", ev(4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00));
    reset = 1'b0;

    // STOR: single-cycle write strobe
    set_instr(4'b0100, 4'b0100, 4'd2, 5'd0);
    fetch("stor");
    cyc("stor_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_WE));

    // MOV
    set_instr(4'b0000, 4'b1101, 4'd1, 5'd0);
    fetch("mov");
    cyc("mov_exec", ev(4'd3, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, E_RW));

    // CMP (register)
    set_instr(4'b0000, 4'b1011, 4'd1, 5'd0);
    fetch("cmp");
    cyc("cmp_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_PSR));

    // CMPI
    set_instr(4'b1011, 4'b0000, 4'd1, 5'd0);
    fetch("cmpi");
    cyc("cmpi_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, E_PSR | E_SE));

    // SUBI
    set_instr(4'b1001, 4'b0000, 4'd1, 5'd0);
    fetch("subi");
    cyc("subi_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, E_ALUO | E_PSR | E_SE));
    cyc("subi_wb", V_ALUWB);

    // MOVI
    set_instr(4'b1101, 4'b0000, 4'd1, 5'd0);
    fetch("movi");
    cyc("movi_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_RW));

    // BEQ with Z set, then with flags clear
    set_instr(4'b1100, 4'b0000, 4'b0000, 5'b01000);
    fetch("beq_t");
`ifdef CTRL_BRANCH_EN
    cyc("beq_t_exec", ev(4'd3, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, E_PC | E_SE));
`else
    cyc("beq_t_exec", V_NOP_EX);
`endif
    set_instr(4'b1100, 4'b0000, 4'b0000, 5'b00000);
    fetch("beq_nt");
    cyc("beq_nt_exec", V_NOP_EX);

    // Unconditional Jcond
    set_instr(4'b0100, 4'b1100, 4'b1110, 5'b00000);
    fetch("juc");
`ifdef CTRL_BRANCH_EN
    cyc("juc_exec", ev(4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, E_PC));
`else
    cyc("juc_exec", V_NOP_EX);
`endif

    // Undecoded opcode is a 4-cycle NOP, then fetch resumes
    set_instr(4'b1111, 4'b0000, 4'd0, 5'd0);
    fetch("nop");
    cyc("nop_exec", V_NOP_EX);
    cyc("nop_next_f0", ev(4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'h00));

    @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
